// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU datapath blocks.
//   divState_e : sequencing states of the multi-cycle divide unit
//   ALU_W      : datapath operand width
//   DIV_ITERS  : restoring-divide iterations (one quotient bit per iteration)
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } divState_e;

    localparam int ALU_W     = 8;
    localparam int DIV_ITERS = 8;

endpackage

// File: rtl/subtractor_8bit.sv
// ---------------------------------------------------------------------------
// subtractor_8bit
// Combinational modulo-256 subtractor, diff_o = a_i - b_i.
// Ports:
//   a_i    [7:0] in  : minuend
//   b_i    [7:0] in  : subtrahend
//   diff_o [7:0] out : difference, wraps mod 256
// ---------------------------------------------------------------------------
module subtractor_8bit
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a_i,
    input  logic [ALU_W-1:0] b_i,
    output logic [ALU_W-1:0] diff_o
);

    // Plain wrap-around difference; callers decide when the result is meaningful.
    assign diff_o = a_i - b_i;

endmodule

// File: rtl/divider_seq_8bit.sv
// ---------------------------------------------------------------------------
// divider_seq_8bit
// Multi-cycle unsigned 8-bit restoring divider. One trial subtraction per
// clock through a single subtractor_8bit; eight iterations per operation.
// Ports:
//   clk        in  : clock, rising edge
//   rst        in  : asynchronous active-high reset
//   start      in  : request, sampled only while ready is high
//   dividend   in  : numerator, captured on the accepting edge
//   divisor    in  : denominator, captured on the accepting edge
//   ready      out : idle, will accept start
//   done       out : one-cycle pulse, results valid while high
//   quotient   out : result, held until the next accepted start
//   remainder  out : result, held until the next accepted start
//   err        out : divide-by-zero flag, valid with done
// Build option:
//   DIV_ZERO_CHK_EN : short-circuit a zero divisor straight to DONE with
//                     err=1, quotient=8'hFF, remainder=dividend.
//                     Undefined: err is tied low and a zero divisor runs the
//                     normal iterations (which give the same results).
// ---------------------------------------------------------------------------
module divider_seq_8bit
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ALU_W-1:0] dividend,
    input  logic [ALU_W-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [ALU_W-1:0] quotient,
    output logic [ALU_W-1:0] remainder,
    output logic             err
);

    // The subtractor is fixed at 8 bits, so any other width cannot be built.
    generate
        if (WIDTH != ALU_W) begin : gWidthCheck
            $error("divider_seq_8bit: WIDTH must be 8");
        end
    endgenerate

    divState_e        state_q;
    logic [2:0]       iterCnt_q;
    logic [ALU_W-1:0] divisor_q;
    logic [ALU_W-1:0] quotSh_q;
    logic [ALU_W-1:0] partRem_q;
    logic [ALU_W-1:0] quotient_q;
    logic [ALU_W-1:0] remainder_q;

    logic [ALU_W:0]   trial;
    logic [ALU_W-1:0] trialDiff;
    logic             trialFits;
    logic [ALU_W-1:0] partRem_d;
    logic [ALU_W-1:0] quotSh_d;

    // Shift the next dividend bit into the partial remainder. The 9th bit
    // matters: if it is set, T is at least 256 and always exceeds D, and the
    // mod-256 difference is then still the correct new remainder.
    assign trial = {partRem_q, quotSh_q[ALU_W-1]};

    subtractor_8bit uSub (
        .a_i    (trial[ALU_W-1:0]),
        .b_i    (divisor_q),
        .diff_o (trialDiff)
    );

    always_comb begin
        trialFits = trial[ALU_W] | (trial[ALU_W-1:0] >= divisor_q);
        partRem_d = trialFits ? trialDiff : trial[ALU_W-1:0];
        quotSh_d  = {quotSh_q[ALU_W-2:0], trialFits};
    end

    // Sequencer and datapath registers. Results are copied out only on the
    // final iteration so the visible outputs hold steady during a run.
`ifdef DIV_ZERO_CHK_EN
    logic err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            iterCnt_q   <= '0;
            divisor_q   <= '0;
            quotSh_q    <= '0;
            partRem_q   <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
`ifdef DIV_ZERO_CHK_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        divisor_q <= divisor;
                        quotSh_q  <= dividend;
                        partRem_q <= '0;
                        iterCnt_q <= 3'(DIV_ITERS - 1);
`ifdef DIV_ZERO_CHK_EN
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            quotient_q  <= '1;
                            remainder_q <= dividend;
                            err_q       <= 1'b1;
                        end else begin
                            state_q     <= RUN;
                            err_q       <= 1'b0;
                        end
`else
                        state_q <= RUN;
`endif
                    end
                end
                RUN: begin
                    partRem_q <= partRem_d;
                    quotSh_q  <= quotSh_d;
                    if (iterCnt_q == '0) begin
                        state_q     <= DONE;
                        quotient_q  <= quotSh_d;
                        remainder_q <= partRem_d;
                    end else begin
                        iterCnt_q <= iterCnt_q - 3'd1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quotient_q;
    assign remainder = remainder_q;

`ifdef DIV_ZERO_CHK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_divider_seq_8bit.sv
// ---------------------------------------------------------------------------
// tb_divider_seq_8bit
// Self-checking bench for divider_seq_8bit: directed vector table, back-to-back
// handshake, reset during a run, and a random sweep against / and %.
// ---------------------------------------------------------------------------
module tb_divider_seq_8bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       err;

    int checks;
    int errors;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       e;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    divider_seq_8bit #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .err       (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it, and reports a failure with both values.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual %0d, required %0d", name, actual, expected);
        end
    endtask

    // Waits for ready, issues one request, then returns how many edges after
    // the accepting edge done was seen high (-1 on timeout). Returns on the
    // falling edge where done is high so results can be checked directly.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 output int doneEdge);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("readyBeforeStart", 32'(ready), 32'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        doneEdge = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                doneEdge = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int lat;
        int doneSeen;
        int doneEdges[$];
        logic [7:0] ra;
        logic [7:0] rb;

        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;

        // Reset state
        #1;
        checkOutput("resetQuotient", 32'(quotient), 32'd0);
        checkOutput("resetRemainder", 32'(remainder), 32'd0);
        checkOutput("resetErr", 32'(err), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        checkOutput("resetReady", 32'(ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Directed vectors; done is expected 8 edges after acceptance
        vecs[0] = '{a: 8'd200, b: 8'd7,   q: 8'd28,  r: 8'd4,   e: 1'b0, lat: 8};
        vecs[1] = '{a: 8'd5,   b: 8'd10,  q: 8'd0,   r: 8'd5,   e: 1'b0, lat: 8};
        vecs[2] = '{a: 8'd10,  b: 8'd5,   q: 8'd2,   r: 8'd0,   e: 1'b0, lat: 8};
        vecs[3] = '{a: 8'd128, b: 8'd128, q: 8'd1,   r: 8'd0,   e: 1'b0, lat: 8};
        vecs[4] = '{a: 8'd255, b: 8'd255, q: 8'd1,   r: 8'd0,   e: 1'b0, lat: 8};
        vecs[5] = '{a: 8'd0,   b: 8'd3,   q: 8'd0,   r: 8'd0,   e: 1'b0, lat: 8};
        vecs[6] = '{a: 8'd255, b: 8'd16,  q: 8'd15,  r: 8'd15,  e: 1'b0, lat: 8};
`ifdef DIV_ZERO_CHK_EN
        vecs[7] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, e: 1'b1, lat: 0};
`else
        vecs[7] = '{a: 8'd100, b: 8'd0,   q: 8'd255, r: 8'd100, e: 1'b0, lat: 8};
`endif

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, lat);
            checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            checkOutput($sformatf("vec%0d_quotient", i), 32'(quotient), 32'(vecs[i].q));
            checkOutput($sformatf("vec%0d_remainder", i), 32'(remainder), 32'(vecs[i].r));
            checkOutput($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].e));
            // done must be a single-cycle pulse
            @(negedge clk);
            checkOutput($sformatf("vec%0d_donePulse", i), 32'(done), 32'd0);
            checkOutput($sformatf("vec%0d_holdQuotient", i), 32'(quotient), 32'(vecs[i].q));
        end

        // Back-to-back 255/1 then 135/10 with start held high throughout
        @(negedge clk);
        checkOutput("b2bReadyIdle", 32'(ready), 32'd1);
        dividend = 8'd255;
        divisor  = 8'd1;
        start    = 1'b1;
        for (int e = 0; e <= 22; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (e == 0) begin
                dividend = 8'd135;
                divisor  = 8'd10;
            end
            if (done) begin
                doneEdges.push_back(e);
                if (doneEdges.size() == 1) begin
                    checkOutput("b2bFirstQuotient", 32'(quotient), 32'd255);
                    checkOutput("b2bFirstRemainder", 32'(remainder), 32'd0);
                end else begin
                    checkOutput("b2bSecondQuotient", 32'(quotient), 32'd13);
                    checkOutput("b2bSecondRemainder", 32'(remainder), 32'd5);
                end
            end
            if (e == 4) checkOutput("b2bReadyInRun", 32'(ready), 32'd0);
            if (e == 9) begin
                checkOutput("b2bReadyAfterE9", 32'(ready), 32'd1);
                checkOutput("b2bHoldInIdle", 32'(quotient), 32'd255);
            end
            if (e == 10) checkOutput("b2bAcceptE10", 32'(ready), 32'd0);
        end
        start = 1'b0;
        checkOutput("b2bDoneCount", 32'(doneEdges.size()), 32'd2);
        if (doneEdges.size() >= 2) begin
            checkOutput("b2bFirstDoneEdge", 32'(doneEdges[0]), 32'd8);
            checkOutput("b2bSecondDoneEdge", 32'(doneEdges[1]), 32'd18);
        end

        // Reset three cycles into a 200/7 run; previous results are non-zero
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midRstQuotient", 32'(quotient), 32'd0);
        checkOutput("midRstRemainder", 32'(remainder), 32'd0);
        checkOutput("midRstErr", 32'(err), 32'd0);
        checkOutput("midRstDone", 32'(done), 32'd0);
        checkOutput("midRstReady", 32'(ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done) doneSeen++;
        end
        checkOutput("midRstNoDone", 32'(doneSeen), 32'd0);

        // Random non-zero divisors against the language's / and %
        for (int i = 0; i < 300; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(1, 255));
            applyStimulus(ra, rb, lat);
            if (lat != 8 || quotient !== ra / rb || remainder !== ra % rb || err !== 1'b0) begin
                checkOutput($sformatf("rand_%0d_%0d_latency", ra, rb), 32'(lat), 32'd8);
                checkOutput($sformatf("rand_%0d_%0d_quotient", ra, rb), 32'(quotient), 32'(ra / rb));
                checkOutput($sformatf("rand_%0d_%0d_remainder", ra, rb), 32'(remainder), 32'(ra % rb));
                checkOutput($sformatf("rand_%0d_%0d_err", ra, rb), 32'(err), 32'd0);
            end else begin
                checks++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard stop if the bench itself stalls.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/divider_seq_8bit.md
# divider_seq_8bit

Multi-cycle unsigned 8-bit restoring divider that sequences a single instance of the team's combinational `subtractor_8bit` for one trial subtraction per cycle. It accepts a dividend/divisor pair on a start/ready handshake, runs eight iterations, and presents the quotient and remainder with a one-cycle done pulse. It is the ALU's divide unit and the first sequential consumer of the subtractor.

## Interface
- `WIDTH`, default 8: operand width. Only 8 is supported because `subtractor_8bit` is fixed-width. Any other value is a configuration error.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: request. Sampled only when `ready`=1.
- `dividend` input 8: unsigned numerator. Captured on the accepting edge.
- `divisor` input 8: unsigned denominator. Captured on the accepting edge.
- `ready` output 1: block is idle and will accept `start`.
- `done` output 1: one-cycle pulse. `quotient`, `remainder` and `err` are valid while it is high.
- `quotient` output 8: result. Held until the next accepted start.
- `remainder` output 8: result. Held until the next accepted start.
- `err` output 1: divide-by-zero flag. Valid with `done`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on `start`=1 at an edge.
  - Latch the divisor into D.
  - Latch the dividend into the shift register Q.
  - Clear the partial remainder R.
  - Set the iteration counter to 7.
- RUN, one iteration per edge:
  - T = {R, Q[7]} (9 bits). Shift Q left.
  - `subtractor_8bit` computes T[7:0] − D.
  - If T[8]=1 or T[7:0] ≥ D: R ← the subtractor output and Q[0] ← 1.
  - Otherwise: R ← T[7:0] and Q[0] ← 0.
  - Arithmetic is mod 256. The subtractor output is correct whenever the compare passes.
- RUN → DONE after the iteration with counter=0. DONE → IDLE unconditionally on the next edge.
- `ready` = (state == IDLE). `done` = (state == DONE).
- `quotient` ← Q and `remainder` ← R are loaded on the RUN→DONE edge. They are held through IDLE.
- `start` is ignored in RUN and DONE; there is no queueing. Operand inputs are don't-care except on the accepting edge.
- Reset, including reset asserted mid-operation:
  - state=IDLE, counter=0.
  - `quotient`=0, `remainder`=0, `err`=0, `done`=0, `ready`=1.
  - Any in-flight result is discarded.

## Timing
- Edge E0 accepts `start`. Iterations run on E1..E8.
- `done`=1 in the cycle after E8; `ready`=0 from E0 until E9.
- `ready`=1 again after E9. A new start is accepted at the earliest on E10, so there is one idle cycle between operations.
- Nine cycles from acceptance to done.
- The subtract/compare path is combinational within one cycle. There are no multicycle paths.

## Configuration
- `DIV_ZERO_CHK_EN` defined:
  - An accepted start with `divisor`=0 goes IDLE→DONE directly on E0, skipping RUN.
  - `done`=1 in the cycle after E0.
  - Outputs: `err`=1, `quotient`=8'hFF, `remainder`=dividend.
  - `err`=0 for every non-zero divisor.
- `DIV_ZERO_CHK_EN` undefined:
  - A zero divisor runs the normal 8 iterations. This naturally yields `quotient`=8'hFF and `remainder`=dividend.
  - `err` is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum (IDLE/RUN/DONE),
  - the `ALU_W`=8 constant,
  - the `DIV_ITERS`=8 constant.
- One sub-module: the existing `subtractor_8bit`, instantiated once with operands T[7:0] and D.
- The compare and registers live in `divider_seq_8bit`. No second sub-module.

## Test plan
- Reset mid-RUN: assert `rst` 3 cycles after accepting 200/7 → outputs immediately 0, `ready`=1, and no `done` pulse follows.
- Basic 200/7 → `done` 9 cycles after acceptance with `quotient`=28, `remainder`=4, `err`=0.
- Back-to-back operations 255/1 then 135/10 (decimal), with `start` held high throughout:
  - First result 255 r 0, second result 13 r 5.
  - Second acceptance on E10.
  - Assertion: `start` during RUN/DONE never restarts the operation.
- Boundary 5/10 → 0 r 5; 10/5 → 2 r 0; 128/128 → 1 r 0; 255/255 → 1 r 0.
- Divide by zero 100/0:
  - With `DIV_ZERO_CHK_EN`: `done` 1 cycle after acceptance, `err`=1, results 255 r 100.
  - Without it: `done` after 9 cycles, `err`=0, results 255 r 100.
- Random regression: 10k random pairs with non-zero divisor compared against a reference model → `quotient`×`divisor`+`remainder`=`dividend` and `remainder`<`divisor`.
